// File: rtl/stream_arb_rr_pkg.sv
// Shared stream constants and helpers for the round-robin stream arbiter.
package stream_arb_rr_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int bits;
    bits = 32'sd0;
    while ((32'sd1 << bits) < value) begin
      bits = bits + 32'sd1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/stream_arb_rr_buf.sv
// Single-entry registered stream stage; accepts whenever empty or being drained.
module stream_buf_v #(
  parameter int DataBits = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DataBits-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DataBits-1:0] out_data
);

  logic                valid_q;
  logic                valid_d;
  logic [DataBits-1:0] data_q;
  logic [DataBits-1:0] data_d;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next-state for the holding register
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Only the valid flag is reset; payload is qualified by it
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload register
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/stream_arb_rr.sv
// Packet-atomic round-robin arbiter merging NumInputs streams into one registered output.
module stream_arb_rr
  import stream_arb_rr_pkg::*;
#(
  parameter  int NumInputs = 4,
  parameter  int DataBits  = 8,
  localparam int SelBits   = clog2(NumInputs)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumInputs-1:0]          in_enable,
  input  logic [NumInputs-1:0]          in_valid,
  output logic [NumInputs-1:0]          in_ready,
  input  logic [NumInputs*DataBits-1:0] in_data,
  input  logic [NumInputs-1:0]          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DataBits-1:0]           out_data,
  output logic                          out_last,
  output logic [SelBits-1:0]            out_sel,
  output logic                          busy
);

  localparam int BufBits = DataBits + 1 + SelBits;

  arb_state_e           state_q;
  arb_state_e           state_d;
  logic [SelBits-1:0]   rr_ptr_q;
  logic [SelBits-1:0]   rr_ptr_d;
  logic [SelBits-1:0]   grant_q;
  logic [SelBits-1:0]   grant_d;

  logic [NumInputs-1:0] req_s;
  logic                 pick_found_s;
  logic [SelBits-1:0]   pick_idx_s;
  logic                 buf_in_valid_s;
  logic                 buf_in_ready_s;
  logic                 grant_last_s;
  logic [DataBits-1:0]  grant_data_s;
  logic [NumInputs-1:0] in_ready_s;
  logic [BufBits-1:0]   buf_out_s;

  assign req_s          = in_valid & in_enable;
  assign busy           = (state_q == ST_LOCKED);
  assign buf_in_valid_s = (state_q == ST_LOCKED) & in_valid[grant_q];
  assign grant_last_s   = in_last[grant_q];
  assign grant_data_s   = in_data[int'(grant_q)*DataBits +: DataBits];
  assign in_ready       = in_ready_s;

  // First requester at or after rr_ptr, wrapping past the top index
  always_comb begin
    int idx;
    pick_found_s = 1'b0;
    pick_idx_s   = rr_ptr_q;
    for (int k = 0; k < NumInputs; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NumInputs) begin
        idx = idx - NumInputs;
      end else begin
        idx = idx;
      end
      if (!pick_found_s && req_s[idx]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = SelBits'(idx);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Only the locked input sees the output stage's ready
  always_comb begin
    in_ready_s = {NumInputs{1'b0}};
    if (state_q == ST_LOCKED) begin
      in_ready_s[grant_q] = buf_in_ready_s;
    end else begin
      in_ready_s = {NumInputs{1'b0}};
    end
  end

  // Arbitration FSM next state; enable is only consulted while idle
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          grant_d = pick_idx_s;
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (buf_in_valid_s && buf_in_ready_s && grant_last_s) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_q == SelBits'(NumInputs - 1)) ? {SelBits{1'b0}}
                                                          : grant_q + 1'b1;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= {SelBits{1'b0}};
      grant_q  <= {SelBits{1'b0}};
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  stream_buf_v #(
    .DataBits(BufBits)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (buf_in_valid_s),
    .in_ready (buf_in_ready_s),
    .in_data  ({grant_q, grant_last_s, grant_data_s}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_out_s)
  );

  assign {out_sel, out_last, out_data} = buf_out_s;

endmodule
